// File: rtl/sdq_fifo_ctrl_if.sv
// Producer, consumer and SRAM-side signals of the SRAM-backed FIFO controller.
// The slave modport is the controller's view; master is the environment's.
interface sdq_fifo_if #(
    parameter int BITS       = 64,
    parameter int ADDR_WIDTH = 5
) ();
    logic                  push_valid_in;
    logic [BITS-1:0]       push_data_in;
    logic                  push_ready_out;
    logic                  pop_valid_out;
    logic [BITS-1:0]       pop_data_out;
    logic                  pop_ready_in;
    logic [4:0]            count_out;
    logic                  mem_ce_out;
    logic                  mem_we_out;
    logic [ADDR_WIDTH-1:0] mem_addr_out;
    logic [BITS-1:0]       mem_wd_out;
    logic [BITS-1:0]       mem_rd_in;

    modport slave (
        input  push_valid_in, push_data_in, pop_ready_in, mem_rd_in,
        output push_ready_out, pop_valid_out, pop_data_out, count_out,
        output mem_ce_out, mem_we_out, mem_addr_out, mem_wd_out
    );

    modport master (
        output push_valid_in, push_data_in, pop_ready_in, mem_rd_in,
        input  push_ready_out, pop_valid_out, pop_data_out, count_out,
        input  mem_ce_out, mem_we_out, mem_addr_out, mem_wd_out
    );
endinterface

// File: rtl/sdq_fifo_ctrl.sv
// FIFO controller over a single-port SRAM with a 2-entry output buffer.
// One SRAM access per cycle; reads and writes alternate when both are wanted.
module sdq_fifo_ctrl #(
    parameter int BITS       = 64,
    parameter int WORD_DEPTH = 17,
    parameter int ADDR_WIDTH = 5
) (
    input  logic      clk,
    input  logic      reset,
    sdq_fifo_if.slave bus
);
    localparam int CNT_W = ADDR_WIDTH + 1;

    typedef enum logic {OP_WRITE = 1'b0, OP_READ = 1'b1} op_e;

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      sram_cnt_q, sram_cnt_d;
    logic [1:0]            obuf_cnt_q, obuf_cnt_d;
    logic                  inflight_q, inflight_d;
    op_e                   last_op_q, last_op_d;
    logic [BITS-1:0]       obuf_q [2];
    logic [BITS-1:0]       obuf_d [2];

    logic       pop_valid, pop_fire;
    logic       rd_elig, wr_elig, read_issue, write_issue;
    logic [1:0] obuf_after_pop;
    logic       tail;

    function automatic logic [ADDR_WIDTH-1:0] ptr_inc(input logic [ADDR_WIDTH-1:0] p);
        return (p == ADDR_WIDTH'(WORD_DEPTH - 1)) ? '0 : p + ADDR_WIDTH'(1);
    endfunction

    // Grant logic; gated by reset so nothing is issued before the first edge with reset low.
    always_comb begin
        pop_valid      = (obuf_cnt_q != 2'd0);
        pop_fire       = pop_valid & bus.pop_ready_in;
        obuf_after_pop = obuf_cnt_q - {1'b0, pop_fire};
        rd_elig        = !reset && (sram_cnt_q != '0)
                         && (({1'b0, obuf_after_pop} + {2'b00, inflight_q}) < 3'd2);
        wr_elig        = !reset && bus.push_valid_in && (sram_cnt_q < CNT_W'(WORD_DEPTH));
        read_issue     = rd_elig && (!wr_elig || (last_op_q == OP_WRITE));
        write_issue    = wr_elig && !read_issue;
    end

    always_comb begin
        wr_ptr_d   = write_issue ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = read_issue  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        sram_cnt_d = sram_cnt_q + CNT_W'(write_issue) - CNT_W'(read_issue);
        inflight_d = read_issue;
        last_op_d  = last_op_q;
        if (read_issue) begin
            last_op_d = OP_READ;
        end else if (write_issue) begin
            last_op_d = OP_WRITE;
        end
        // Pop shifts the head out first, so the returning read lands behind what remains.
        obuf_d[0] = obuf_q[0];
        obuf_d[1] = obuf_q[1];
        tail      = obuf_after_pop[0];
        if (pop_fire) begin
            obuf_d[0] = obuf_q[1];
        end
        if (inflight_q) begin
            obuf_d[tail] = bus.mem_rd_in;
        end
        obuf_cnt_d = obuf_after_pop + {1'b0, inflight_q};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            sram_cnt_q <= '0;
            obuf_cnt_q <= '0;
            inflight_q <= 1'b0;
            last_op_q  <= OP_WRITE;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            sram_cnt_q <= sram_cnt_d;
            obuf_cnt_q <= obuf_cnt_d;
            inflight_q <= inflight_d;
            last_op_q  <= last_op_d;
        end
    end

    always_ff @(posedge clk) begin
        obuf_q[0] <= obuf_d[0];
        obuf_q[1] <= obuf_d[1];
    end

    assign bus.push_ready_out = write_issue;
    assign bus.pop_valid_out  = pop_valid;
    assign bus.pop_data_out   = obuf_q[0];
    assign bus.count_out      = 5'(sram_cnt_q + CNT_W'(inflight_q) + CNT_W'(obuf_cnt_q));
    assign bus.mem_ce_out     = read_issue | write_issue;
    assign bus.mem_we_out     = write_issue;
    assign bus.mem_addr_out   = write_issue ? wr_ptr_q : rd_ptr_q;
    assign bus.mem_wd_out     = bus.push_data_in;
endmodule

// File: tb/tb_sdq_fifo_ctrl.sv
// Directed bench for sdq_fifo_ctrl: behavioural SRAM, data-order scoreboard,
// immediate-assertion checks at each comparison point.
module tb_sdq_fifo_ctrl;
    logic clk = 1'b0;
    logic reset;

    sdq_fifo_if #(.BITS(64), .ADDR_WIDTH(5)) bus ();

    sdq_fifo_ctrl #(.BITS(64), .WORD_DEPTH(17), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Single-port SRAM: read data appears the cycle after the read.
    logic [63:0] sram [0:31];
    logic [63:0] rd_q = 64'd0;
    always @(posedge clk) begin
        if (bus.mem_ce_out) begin
            if (bus.mem_we_out) sram[bus.mem_addr_out] <= bus.mem_wd_out;
            else                rd_q <= sram[bus.mem_addr_out];
        end
    end
    assign bus.mem_rd_in = rd_q;

    int n_cmp = 0;
    int n_err = 0;
    logic [63:0] q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs just after the edge and let outputs settle until the falling edge.
    task automatic drive(input logic pv, input logic [63:0] pd, input logic pr);
        bus.push_valid_in = pv;
        bus.push_data_in  = pd;
        bus.pop_ready_in  = pr;
        #4;
    endtask

    // Record this cycle's handshakes in the scoreboard, then advance one clock.
    task automatic commit();
        logic [63:0] e;
        if (bus.pop_valid_out && bus.pop_ready_in) begin
            if (q.size() > 0) e = q.pop_front();
            else              e = 64'hBAD0_BAD0_BAD0_BAD0;
            chk("pop_data", bus.pop_data_out, e);
        end
        if (bus.push_valid_in && bus.push_ready_out) q.push_back(bus.push_data_in);
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [63:0] d);
        drive(1'b1, d, 1'b0);
        for (int k = 0; k < 8 && !bus.push_ready_out; k++) begin
            commit();
            drive(1'b1, d, 1'b0);
        end
        chk("push_accept", 64'(bus.push_ready_out), 64'd1);
        commit();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1'b0, 64'd0, 1'b0);
            commit();
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && q.size() > 0; k++) begin
            drive(1'b0, 64'd0, 1'b1);
            commit();
        end
        drive(1'b0, 64'd0, 1'b0);
        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("drain_count", 64'(bus.count_out), 64'd0);
        chk("drain_pop_valid", 64'(bus.pop_valid_out), 64'd0);
        commit();
    endtask

    initial begin
        int pushed, wraps, last_wa, dnum;
        logic pv, pr, acc, prev_we;

        reset = 1'b1;
        bus.push_valid_in = 1'b0;
        bus.push_data_in  = 64'd0;
        bus.pop_ready_in  = 1'b0;
        @(posedge clk);
        #1;

        // Reset state, with a push offered to confirm nothing is granted.
        drive(1'b1, 64'h77, 1'b0);
        chk("rst_push_ready", 64'(bus.push_ready_out), 64'd0);
        chk("rst_pop_valid", 64'(bus.pop_valid_out), 64'd0);
        chk("rst_mem_ce", 64'(bus.mem_ce_out), 64'd0);
        chk("rst_mem_we", 64'(bus.mem_we_out), 64'd0);
        chk("rst_count", 64'(bus.count_out), 64'd0);
        drive(1'b0, 64'd0, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single word: write cycle 0, read cycle 1, visible cycle 3.
        drive(1'b1, 64'hA5A5, 1'b0);
        chk("sw_c0_push_ready", 64'(bus.push_ready_out), 64'd1);
        chk("sw_c0_mem_we", 64'(bus.mem_we_out), 64'd1);
        chk("sw_c0_mem_ce", 64'(bus.mem_ce_out), 64'd1);
        chk("sw_c0_addr", 64'(bus.mem_addr_out), 64'd0);
        chk("sw_c0_wd", bus.mem_wd_out, 64'hA5A5);
        commit();
        drive(1'b0, 64'd0, 1'b0);
        chk("sw_c1_mem_ce", 64'(bus.mem_ce_out), 64'd1);
        chk("sw_c1_mem_we", 64'(bus.mem_we_out), 64'd0);
        chk("sw_c1_addr", 64'(bus.mem_addr_out), 64'd0);
        chk("sw_c1_count", 64'(bus.count_out), 64'd1);
        chk("sw_c1_pop_valid", 64'(bus.pop_valid_out), 64'd0);
        commit();
        drive(1'b0, 64'd0, 1'b0);
        chk("sw_c2_pop_valid", 64'(bus.pop_valid_out), 64'd0);
        chk("sw_c2_mem_ce", 64'(bus.mem_ce_out), 64'd0);
        commit();
        drive(1'b0, 64'd0, 1'b1);
        chk("sw_c3_pop_valid", 64'(bus.pop_valid_out), 64'd1);
        chk("sw_c3_pop_data", bus.pop_data_out, 64'hA5A5);
        chk("sw_c3_count", 64'(bus.count_out), 64'd1);
        commit();
        drive(1'b0, 64'd0, 1'b0);
        chk("sw_c4_count", 64'(bus.count_out), 64'd0);
        chk("sw_c4_pop_valid", 64'(bus.pop_valid_out), 64'd0);
        chk("empty_mem_ce", 64'(bus.mem_ce_out), 64'd0);
        commit();

        // Fill to 19, refuse the 20th, then drain in order.
        for (int i = 0; i < 19; i++) push_one(64'h1000 + 64'(i));
        idle(3);
        drive(1'b1, 64'h2000, 1'b0);
        chk("full_count", 64'(bus.count_out), 64'd19);
        chk("full_push_ready", 64'(bus.push_ready_out), 64'd0);
        chk("full_pop_valid", 64'(bus.pop_valid_out), 64'd1);
        chk("full_mem_ce", 64'(bus.mem_ce_out), 64'd0);
        commit();
        drive(1'b1, 64'h2000, 1'b0);
        chk("full_push_refused", 64'(bus.push_ready_out), 64'd0);
        commit();
        drain();

        // Wrap: 40 pushes and pops with random handshakes; wr_ptr starts at 3.
        pushed  = 0;
        wraps   = 0;
        last_wa = -1;
        for (int k = 0; k < 2000 && !(pushed == 40 && q.size() == 0); k++) begin
            pv = (pushed < 40) && ($urandom_range(3) != 0);
            pr = 1'($urandom_range(1));
            drive(pv, 64'h3000 + 64'(pushed), pr);
            if (bus.mem_ce_out && bus.mem_we_out) begin
                if (last_wa == 16 && int'(bus.mem_addr_out) == 0) wraps++;
                last_wa = int'(bus.mem_addr_out);
            end
            if (pv && bus.push_ready_out) pushed++;
            commit();
        end
        chk("wrap_pushed", 64'(pushed), 64'd40);
        chk("wrap_drained", 64'(q.size()), 64'd0);
        chk("wrap_ptr_wraps", 64'(wraps), 64'd2);
        drive(1'b0, 64'd0, 1'b0);
        chk("wrap_count", 64'(bus.count_out), 64'd0);
        commit();

        // Reset with a read in flight at count 7.
        for (int i = 0; i < 8; i++) push_one(64'h4000 + 64'(i));
        idle(3);
        drive(1'b0, 64'd0, 1'b1);
        chk("rif_pop_valid", 64'(bus.pop_valid_out), 64'd1);
        chk("rif_read_issue", 64'({bus.mem_ce_out, bus.mem_we_out}), 64'd2);
        commit();
        bus.push_valid_in = 1'b1;
        bus.push_data_in  = 64'h4444;
        bus.pop_ready_in  = 1'b0;
        #1;
        chk("rif_count_before", 64'(bus.count_out), 64'd7);
        reset = 1'b1;
        #1;
        chk("rif_push_ready", 64'(bus.push_ready_out), 64'd0);
        chk("rif_pop_valid_rst", 64'(bus.pop_valid_out), 64'd0);
        chk("rif_mem_ce", 64'(bus.mem_ce_out), 64'd0);
        chk("rif_mem_we", 64'(bus.mem_we_out), 64'd0);
        chk("rif_count_rst", 64'(bus.count_out), 64'd0);
        q.delete();
        @(posedge clk);
        #1;
        chk("rif_hold_mem_ce", 64'(bus.mem_ce_out), 64'd0);
        chk("rif_hold_count", 64'(bus.count_out), 64'd0);
        bus.push_valid_in = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(1'b1, 64'h1, 1'b0);
        chk("post_rst_push_ready", 64'(bus.push_ready_out), 64'd1);
        chk("post_rst_addr", 64'(bus.mem_addr_out), 64'd0);
        commit();
        idle(1);
        drive(1'b0, 64'd0, 1'b0);
        chk("post_rst_c2_pop_valid", 64'(bus.pop_valid_out), 64'd0);
        commit();
        drive(1'b0, 64'd0, 1'b1);
        chk("post_rst_c3_pop_valid", 64'(bus.pop_valid_out), 64'd1);
        chk("post_rst_pop_data", bus.pop_data_out, 64'h1);
        commit();
        drive(1'b0, 64'd0, 1'b0);
        chk("post_rst_no_stale", 64'(bus.pop_valid_out), 64'd0);
        chk("post_rst_count", 64'(bus.count_out), 64'd0);
        commit();

        // Six words, one pop (read granted last), then push+pop together at count 5.
        for (int i = 0; i < 6; i++) push_one(64'h5000 + 64'(i));
        idle(3);
        drive(1'b0, 64'd0, 1'b1);
        chk("c5_pop_read", 64'({bus.mem_ce_out, bus.mem_we_out}), 64'd2);
        commit();
        drive(1'b1, 64'h5100, 1'b1);
        chk("c5_count_before", 64'(bus.count_out), 64'd5);
        chk("c5_push_ready", 64'(bus.push_ready_out), 64'd1);
        chk("c5_pop_valid", 64'(bus.pop_valid_out), 64'd1);
        commit();
        dnum = 1;
        drive(1'b1, 64'h5100 + 64'(dnum), 1'b1);
        chk("c5_count_after", 64'(bus.count_out), 64'd5);

        // Fair arbitration: read/write alternate every cycle with steady valid/ready.
        prev_we = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("arb_mem_ce", 64'(bus.mem_ce_out), 64'd1);
            chk("arb_toggle", 64'(bus.mem_we_out), 64'(!prev_we));
            prev_we = bus.mem_we_out;
            acc = bus.push_ready_out;
            commit();
            if (acc) dnum++;
            drive(1'b1, 64'h5100 + 64'(dnum), 1'b1);
        end
        drive(1'b0, 64'd0, 1'b0);
        commit();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sdq_fifo_ctrl.md
SDQ_FIFO_CTRL -- requirements
Module: sdq_fifo_ctrl

Interface
REQ-001 Parameters SHALL be as follows (one per line: name, default, meaning).
- BITS, 64, data word width.
- WORD_DEPTH, 17, number of words in the attached single-port SRAM.
- ADDR_WIDTH, 5, SRAM address width.
REQ-002 Ports SHALL be as follows (one per line: name, direction, width, meaning).
- clk, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-high reset.
- push_valid_in, in, 1, producer offers push_data_in.
- push_data_in, in, BITS, word to enqueue.
- push_ready_out, out, 1, controller accepts the word this cycle.
- pop_valid_out, out, 1, pop_data_out holds the oldest word.
- pop_data_out, out, BITS, head-of-queue word.
- pop_ready_in, in, 1, consumer takes the word this cycle.
- count_out, out, 5, total words held (SRAM + output buffer + in-flight), range 0..WORD_DEPTH+2.
- mem_ce_out, out, 1, SRAM chip enable.
- mem_we_out, out, 1, SRAM write enable.
- mem_addr_out, out, ADDR_WIDTH, SRAM address.
- mem_wd_out, out, BITS, SRAM write data.
- mem_rd_in, in, BITS, SRAM read data, valid the cycle after a read is issued.
REQ-003 The design SHALL use one clock (clk) and an asynchronous, active-high reset (reset).

Function
REQ-004 The block SHALL be a FIFO of capacity WORD_DEPTH+2: WORD_DEPTH entries in SRAM plus a 2-entry output buffer (obuf).
REQ-005 Handshakes: push on push_valid_in & push_ready_out; pop on pop_valid_out & pop_ready_in; valid SHALL NOT depend combinationally on ready.
REQ-006 At most one SRAM operation per cycle: read_issue, write_issue, or idle.
REQ-007 A read is eligible when sram_cnt > 0 and obuf_cnt + inflight < 2, where obuf_cnt is taken after any pop in the same cycle.
REQ-008 A write is eligible when push_valid_in = 1 and sram_cnt < WORD_DEPTH.
REQ-009 If only one operation is eligible, it SHALL be granted. If both are eligible, the grant SHALL go to the opposite of last_op, a register updated on every grant; last_op resets to "write".
REQ-010 push_ready_out SHALL be 1 exactly when write_issue = 1.
REQ-011 SRAM drive: mem_ce_out = read_issue | write_issue; mem_we_out = write_issue; mem_addr_out = wr_ptr on write, otherwise rd_ptr; mem_wd_out = push_data_in.
REQ-012 wr_ptr and rd_ptr SHALL advance by 1 on their respective grants, wrapping from WORD_DEPTH-1 to 0.
REQ-013 sram_cnt SHALL increment on write_issue and decrement on read_issue; it never moves by 2 in one cycle.
REQ-014 inflight SHALL be set on read_issue. In the following cycle, mem_rd_in SHALL be captured into obuf at the tail and inflight cleared.
REQ-015 obuf is in order: pop_data_out = obuf head. A capture and a pop in the same cycle SHALL both take effect.
REQ-016 Minimum latency: a word pushed in cycle N, with an empty FIFO, SHALL be presented on pop_valid_out in cycle N+3.
REQ-017 count_out SHALL equal sram_cnt + inflight + obuf_cnt; it increments on push, decrements on pop, and is unchanged on a simultaneous push and pop.
REQ-018 Full: at count_out = WORD_DEPTH+2, push_ready_out SHALL be 0. Empty: at count_out = 0, pop_valid_out SHALL be 0 and mem_ce_out SHALL be 0 unless a push is offered.
REQ-019 Data order SHALL be strictly FIFO, including across pointer wrap.

Reset
REQ-020 While reset is high, the following SHALL hold: wr_ptr = rd_ptr = 0, sram_cnt = obuf_cnt = inflight = 0, last_op = write, pop_valid_out = 0, push_ready_out = 0, mem_ce_out = 0, mem_we_out = 0, count_out = 0.
REQ-021 Reset asserted mid-operation SHALL discard all in-flight reads and stored words. SRAM contents need not be cleared; they are treated as empty.
REQ-022 The first grant after reset release SHALL occur no earlier than the first rising edge at which reset is low.

Verification
REQ-023 The bench SHALL cover the following directed scenarios.
- Single word: push 0xA5A5 in cycle 0 into an empty FIFO -> write to addr 0 in cycle 0, read of addr 0 in cycle 1, pop_valid_out = 1 with 0xA5A5 in cycle 3.
- Fill: push 19 words with pop_ready_in = 0 -> count_out = 19, push_ready_out = 0; a 20th push is refused; popping then returns all 19 in order.
- Wrap: perform 40 pushes and 40 pops with random ready -> all data in order; wr_ptr passes 16 -> 0 twice.
- Fair arbitration: push_valid_in = 1 and pop_ready_in = 1 held steady with a non-empty SRAM -> grants alternate read/write every cycle; mem_we_out toggles.
- Simultaneous push and pop at count_out = 5 -> count_out stays 5.
- Reset with a read in flight and count_out = 7 -> all outputs go to their reset values immediately; after release a push of 0x1 pops as 0x1 with no stale data.
